time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
//  Timekeeping and time-set controller for the digital clock. Holds packed-BCD hh:mm:ss,
//  advances it on a 1 Hz tick, and runs a button-driven set-mode FSM. Feeds the display
//  path through the BCD 24h->12h converter h24Toh12Dec, selectable by a 12/24 h format input.
// PARAMETERS
//  RST_HOUR   6'h00  packed-BCD hour loaded on reset (0x00..0x23)
//  RST_MIN    7'h00  packed-BCD minute loaded on reset (0x00..0x59)
//  BLINK_SET  1      1: blink toggles on each tick in set states; 0: blink held 1
// PORTS
//  clk       in   1  system clock
//  nrst      in   1  synchronous reset, active-low
//  tick_1hz  in   1  one-cycle pulse, once per second
//  btn_mode  in   1  one-cycle pulse (debounced upstream); cycles RUN->SET_H->SET_M->RUN
//  btn_inc   in   1  one-cycle pulse; increments the field being edited
//  btn_dec   in   1  one-cycle pulse; decrements the field being edited
//  fmt12     in   1  1: 12 h display, 0: 24 h display (level, sampled combinationally)
//  disp_hour out  6  BCD hour to display; 24 h: hour reg; 12 h: {1'b0, hour12}
//  nAM_PM    out  1  0 = AM, 1 = PM; valid in both formats
//  disp_min  out  7  BCD minutes
//  disp_sec  out  7  BCD seconds
//  edit_fld  out  2  00 none, 01 hour, 10 minute
//  blink     out  1  display blank-enable for the edited field; 1 in RUN
//  day_pulse out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover in RUN
// BEHAVIOUR
//  Reset (nrst=0 at posedge): state RUN, hour=RST_HOUR, min=RST_MIN, sec=0x00,
//   blink=1, day_pulse=0, edit_fld=00. Reset overrides all other inputs, including mid-edit.
//  FSM states: RUN, SET_H, SET_M.
//   RUN  --btn_mode--> SET_H --btn_mode--> SET_M --btn_mode--> RUN.
//   On SET_M->RUN, sec is cleared to 0x00 in the same edge.
//  RUN: on tick_1hz, sec +1. 0x59 wraps to 0x00 and carries into min.
//   min 0x59 wraps and carries into hour. hour 0x23 wraps to 0x00 and asserts day_pulse.
//   Registers update on the edge where tick_1hz=1; there is 1 cycle of latency to the outputs.
//  SET_H / SET_M: time is frozen and tick_1hz does not advance it.
//   btn_inc/btn_dec change only the edited field, with BCD wrap:
//    hour 0x23 -> 0x00 on inc, 0x00 -> 0x23 on dec.
//    min  0x59 -> 0x00 on inc, 0x00 -> 0x59 on dec.
//    ones 9 -> 0 carries into tens (0x09 -> 0x10); 0x10 -> 0x09 on dec.
//   Field wraps in set mode never carry to other fields and never pulse day_pulse.
//   blink toggles on each tick when BLINK_SET=1. blink is forced to 1 on any inc/dec,
//    and to 1 on entry to each set state.
//  Simultaneous events:
//   btn_mode wins over btn_inc/btn_dec; inc/dec are dropped that cycle.
//   btn_inc and btn_dec together: no change.
//   In RUN, inc/dec are ignored.
//  Display: disp_hour, nAM_PM, disp_min and disp_sec are combinational from the registers
//   and fmt12. 12 h mapping: 0x00->0x12 AM; 0x12->0x12 PM; 0x13..0x23 -> 0x01..0x11 PM.
//   A fmt12 change takes effect the same cycle with no state change.
//  All BCD registers stay in their legal range at all times. Illegal RST_* values are a
//   configuration error, flagged by a simulation-only assertion.
// STRUCTURE
//  Shared header clock_defs.vh: FSM state encodings, edit_fld codes, BCD limits
//   (HOUR_MAX=6'h23, MINSEC_MAX=7'h59).
//  Sub-module bcd_field_ctr: parameterized BCD up/down wrap counter with
//   {en_inc, en_dec, max, carry_out}. Instantiated once each for sec, min and hour.
//  Display conversion: one instance of h24Toh12Dec, plus a fmt12 mux.
// TESTING
//  1. Reset with defaults, fmt12=0 -> 00:00:00, disp_hour=0x00, nAM_PM=0, edit_fld=00, blink=1.
//  2. Preload 23:59:58, two ticks -> 23:59:59, then 00:00:00.
//     day_pulse is high for exactly 1 cycle, on the second update.
//  3. Enter SET_H at hour 0x23, inc -> 0x00; dec twice -> 0x22.
//     Ticks meanwhile: sec unchanged, blink toggles.
//  4. SET_M at 0x09: inc -> 0x10. btn_inc+btn_dec together -> 0x10.
//     btn_mode+btn_inc together -> RUN, min 0x10, sec 0x00.
//  5. fmt12=1 sweep: hour 0x00 -> 0x12/AM; 0x11 -> 0x11/AM; 0x12 -> 0x12/PM; 0x23 -> 0x11/PM.
//  6. Assert nrst while in SET_M -> next edge: RUN, RST_HOUR:RST_MIN:00, edit_fld=00.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the digital-clock time-set controller.
//   state_t     : controller FSM states (RUN, SET_H, SET_M)
//   FLD_*       : edit_fld output codes
//   HOUR_MAX,
//   MINSEC_MAX  : packed-BCD upper limits of the hour and min/sec fields
//   bcd_legal() : true when a packed-BCD value has legal digits and is <= max
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2
  } state_t;

  localparam logic [1:0] FLD_NONE = 2'b00;
  localparam logic [1:0] FLD_HOUR = 2'b01;
  localparam logic [1:0] FLD_MIN  = 2'b10;

  localparam logic [5:0] HOUR_MAX   = 6'h23;
  localparam logic [6:0] MINSEC_MAX = 7'h59;

  function automatic logic bcd_legal(input logic [7:0] val, input logic [7:0] max);
    return (val[3:0] <= 4'd9) && (val <= max);
  endfunction

endpackage

// File: rtl/time_set_ctrl_bcd_field_ctr.sv
// Packed-BCD up/down wrap counter for one time field (sec, min or hour).
// Ports:
//   clk, nrst  : clock, synchronous active-low reset (loads RST_VAL)
//   clr        : synchronous clear to zero (beats inc/dec)
//   en_inc     : count up one step, wrapping MAX -> 0
//   en_dec     : count down one step, wrapping 0 -> MAX
//   value      : current packed-BCD field value
//   carry_out  : high while an increment will wrap this cycle
// en_inc and en_dec together leave the field unchanged.
module bcd_field_ctr #(
  parameter int             W       = 7,
  parameter logic [W-1:0]   MAX     = 7'h59,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         en_inc,
  input  logic         en_dec,
  output logic [W-1:0] value,
  output logic         carry_out
);

  localparam int TW = W - 4;

  logic [TW-1:0] tens;
  logic [3:0]    ones;
  logic [W-1:0]  inc_val;
  logic [W-1:0]  dec_val;

  assign tens = value[W-1:4];
  assign ones = value[3:0];

  // Next values in both directions; the ones digit borrows/carries into tens.
  always_comb begin
    inc_val = '0;
    dec_val = '0;
    if (value == MAX)
      inc_val = '0;
    else if (ones == 4'd9)
      inc_val = {tens + TW'(1), 4'd0};
    else
      inc_val = {tens, ones + 4'd1};

    if (value == '0)
      dec_val = MAX;
    else if (ones == 4'd0)
      dec_val = {tens - TW'(1), 4'd9};
    else
      dec_val = {tens, ones - 4'd1};
  end

  assign carry_out = en_inc && !en_dec && (value == MAX);

  always_ff @(posedge clk) begin
    if (!nrst)
      value <= RST_VAL;
    else if (clr)
      value <= '0;
    else if (en_inc && !en_dec)
      value <= inc_val;
    else if (en_dec && !en_inc)
      value <= dec_val;
  end

endmodule

// File: rtl/time_set_ctrl_h24Toh12Dec.sv
// Packed-BCD 24 h -> 12 h hour converter.
// Ports:
//   hour24 : packed-BCD hour 0x00..0x23
//   hour12 : packed-BCD hour 0x01..0x12
//   pm     : 0 = AM (0x00..0x11), 1 = PM (0x12..0x23)
module h24Toh12Dec (
  input  logic [5:0] hour24,
  output logic [4:0] hour12,
  output logic       pm
);

  logic [4:0] bin;
  logic [4:0] bin12;

  // Go through binary for the afternoon hours so the BCD borrow is trivial.
  always_comb begin
    bin    = 5'(hour24[5:4]) * 5'd10 + 5'(hour24[3:0]);
    bin12  = bin - 5'd12;
    pm     = (bin >= 5'd12);
    hour12 = 5'h12;
    if (bin == 5'd0)
      hour12 = 5'h12;
    else if (bin <= 5'd12)
      hour12 = hour24[4:0];
    else if (bin12 >= 5'd10)
      hour12 = {1'b1, 4'(bin12 - 5'd10)};
    else
      hour12 = {1'b0, bin12[3:0]};
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Timekeeping and time-set controller for the digital clock.
// Holds packed-BCD hh:mm:ss, advances it on tick_1hz in RUN, and lets the user
// edit hour and minute with mode/inc/dec buttons.
// Ports:
//   clk, nrst          : clock, synchronous active-low reset
//   tick_1hz           : one-cycle pulse per second
//   btn_mode           : cycles RUN -> SET_H -> SET_M -> RUN
//   btn_inc, btn_dec   : step the edited field up / down
//   fmt12              : 1 = 12 h display, 0 = 24 h display
//   disp_hour, nAM_PM,
//   disp_min, disp_sec : display values (combinational from the registers)
//   edit_fld           : 00 none, 01 hour, 10 minute
//   blink              : blank-enable for the edited field, 1 in RUN
//   day_pulse          : one-cycle pulse on the midnight rollover
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter logic [5:0] RST_HOUR  = 6'h00,
  parameter logic [6:0] RST_MIN   = 7'h00,
  parameter bit         BLINK_SET = 1'b1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       fmt12,
  output logic [5:0] disp_hour,
  output logic       nAM_PM,
  output logic [6:0] disp_min,
  output logic [6:0] disp_sec,
  output logic [1:0] edit_fld,
  output logic       blink,
  output logic       day_pulse
);

  localparam bit CFG_OK = bcd_legal(8'(RST_HOUR), 8'(HOUR_MAX)) &&
                          bcd_legal(8'(RST_MIN),  8'(MINSEC_MAX));

  state_t     state;
  logic [5:0] hour;
  logic [6:0] min;
  logic [6:0] sec;
  logic [4:0] hour12;
  logic       sec_carry;
  logic       min_carry;
  logic       hour_carry;
  logic       in_run;
  logic       tick_run;
  logic       edit_h;
  logic       edit_m;

  assign in_run   = (state == ST_RUN);
  assign tick_run = in_run && tick_1hz;
  // btn_mode swallows any inc/dec arriving in the same cycle.
  assign edit_h   = (state == ST_SET_H) && !btn_mode;
  assign edit_m   = (state == ST_SET_M) && !btn_mode;

  bcd_field_ctr #(.W(7), .MAX(MINSEC_MAX), .RST_VAL(7'h00)) u_sec (
    .clk       (clk),
    .nrst      (nrst),
    .clr       ((state == ST_SET_M) && btn_mode),
    .en_inc    (tick_run),
    .en_dec    (1'b0),
    .value     (sec),
    .carry_out (sec_carry)
  );

  bcd_field_ctr #(.W(7), .MAX(MINSEC_MAX), .RST_VAL(RST_MIN)) u_min (
    .clk       (clk),
    .nrst      (nrst),
    .clr       (1'b0),
    .en_inc    ((tick_run && sec_carry) || (edit_m && btn_inc)),
    .en_dec    (edit_m && btn_dec),
    .value     (min),
    .carry_out (min_carry)
  );

  bcd_field_ctr #(.W(6), .MAX(HOUR_MAX), .RST_VAL(RST_HOUR)) u_hour (
    .clk       (clk),
    .nrst      (nrst),
    .clr       (1'b0),
    .en_inc    ((tick_run && min_carry) || (edit_h && btn_inc)),
    .en_dec    (edit_h && btn_dec),
    .value     (hour),
    .carry_out (hour_carry)
  );

  // Mode FSM with registered edit_fld / blink / day_pulse.
  // In a set state blink is forced high on entry and on any button, else toggles per tick.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= ST_RUN;
      edit_fld  <= FLD_NONE;
      blink     <= 1'b1;
      day_pulse <= 1'b0;
    end else begin
      day_pulse <= tick_run && hour_carry;
      case (state)
        ST_RUN: begin
          blink <= 1'b1;
          if (btn_mode) begin
            state    <= ST_SET_H;
            edit_fld <= FLD_HOUR;
          end
        end
        ST_SET_H, ST_SET_M: begin
          if (btn_mode) begin
            blink <= 1'b1;
            if (state == ST_SET_H) begin
              state    <= ST_SET_M;
              edit_fld <= FLD_MIN;
            end else begin
              state    <= ST_RUN;
              edit_fld <= FLD_NONE;
            end
          end else if (btn_inc || btn_dec) begin
            blink <= 1'b1;
          end else if (tick_1hz && BLINK_SET) begin
            blink <= ~blink;
          end
        end
        default: begin
          state    <= ST_RUN;
          edit_fld <= FLD_NONE;
          blink    <= 1'b1;
        end
      endcase
    end
  end

  h24Toh12Dec u_h12 (
    .hour24 (hour),
    .hour12 (hour12),
    .pm     (nAM_PM)
  );

  assign disp_hour = fmt12 ? {1'b0, hour12} : hour;
  assign disp_min  = min;
  assign disp_sec  = sec;

  // Simulation-only guard against out-of-range reset values.
  a_rst_cfg : assert property (@(posedge clk) CFG_OK);

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

  logic       clk;
  logic       nrst;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic       fmt12;
  logic [5:0] disp_hour;
  logic       nAM_PM;
  logic [6:0] disp_min;
  logic [6:0] disp_sec;
  logic [1:0] edit_fld;
  logic       blink;
  logic       day_pulse;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       mode;
    logic       inc;
    logic       dec;
    logic       tick;
    logic       fmt;
    logic [5:0] hour;
    logic       pm;
    logic [6:0] min;
    logic [6:0] sec;
    logic [1:0] fld;
    logic       blk;
    logic       day;
  } vec_t;

  vec_t vecs[20];

  time_set_ctrl #(.RST_HOUR(6'h00), .RST_MIN(7'h00), .BLINK_SET(1'b1)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .fmt12     (fmt12),
    .disp_hour (disp_hour),
    .nAM_PM    (nAM_PM),
    .disp_min  (disp_min),
    .disp_sec  (disp_sec),
    .edit_fld  (edit_fld),
    .blink     (blink),
    .day_pulse (day_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] h, input logic pm,
                             input logic [6:0] m, input logic [6:0] s, input logic [1:0] f,
                             input logic b, input logic d);
    checkVal({tag, ".hour"},  8'(disp_hour), 8'(h));
    checkVal({tag, ".pm"},    8'(nAM_PM),    8'(pm));
    checkVal({tag, ".min"},   8'(disp_min),  8'(m));
    checkVal({tag, ".sec"},   8'(disp_sec),  8'(s));
    checkVal({tag, ".fld"},   8'(edit_fld),  8'(f));
    checkVal({tag, ".blink"}, 8'(blink),     8'(b));
    checkVal({tag, ".day"},   8'(day_pulse), 8'(d));
  endtask

  // Drive one cycle of pulses at the negedge, return 1 ns after the capturing posedge.
  task automatic applyStimulus(input logic m, input logic i, input logic d, input logic t);
    @(negedge clk);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    tick_1hz = t;
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    tick_1hz = 1'b0;
  endtask

  initial begin
    int h12;

    //            mode  inc   dec   tick  fmt   hour   pm    min    sec    fld    blk   day
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 7'h00, 7'h01, 2'b00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 7'h00, 7'h02, 2'b00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 7'h00, 7'h02, 2'b01, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h23, 1'b1, 7'h00, 7'h02, 2'b01, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 7'h00, 7'h02, 2'b01, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h23, 1'b1, 7'h00, 7'h02, 2'b01, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h22, 1'b1, 7'h00, 7'h02, 2'b01, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h22, 1'b1, 7'h00, 7'h02, 2'b01, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h22, 1'b1, 7'h00, 7'h02, 2'b01, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h22, 1'b1, 7'h00, 7'h02, 2'b01, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h23, 1'b1, 7'h00, 7'h02, 2'b01, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h23, 1'b1, 7'h00, 7'h02, 2'b01, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 1'b1, 7'h00, 7'h02, 2'b10, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'h23, 1'b1, 7'h59, 7'h02, 2'b10, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h23, 1'b1, 7'h00, 7'h02, 2'b10, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h23, 1'b1, 7'h00, 7'h02, 2'b10, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h23, 1'b1, 7'h01, 7'h02, 2'b10, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h23, 1'b1, 7'h01, 7'h00, 2'b00, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'h11, 1'b1, 7'h01, 7'h01, 2'b00, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h23, 1'b1, 7'h01, 7'h01, 2'b00, 1'b1, 1'b0};

    nrst     = 1'b0;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    fmt12    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset", 6'h00, 1'b0, 7'h00, 7'h00, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    nrst = 1'b1;

    // Main directed table: run ticks, hour edit with wraps, minute edit, exit.
    for (int i = 0; i < 20; i++) begin
      fmt12 = vecs[i].fmt;
      applyStimulus(vecs[i].mode, vecs[i].inc, vecs[i].dec, vecs[i].tick);
      checkOutput($sformatf("vec%0d", i), vecs[i].hour, vecs[i].pm, vecs[i].min,
                  vecs[i].sec, vecs[i].fld, vecs[i].blk, vecs[i].day);
    end

    // Midnight rollover: set 23:59, run to 23:59:58, then two ticks.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("roll.set", 6'h23, 1'b1, 7'h59, 7'h00, 2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 58; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("roll.58", 6'h23, 1'b1, 7'h59, 7'h58, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("roll.59", 6'h23, 1'b1, 7'h59, 7'h59, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("roll.00", 6'h00, 1'b0, 7'h00, 7'h00, 2'b00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("roll.idle", 6'h00, 1'b0, 7'h00, 7'h00, 2'b00, 1'b1, 1'b0);

    // Minute ones->tens carry and borrow, inc+dec cancel, mode beats inc.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("setm.09", 6'h00, 1'b0, 7'h09, 7'h00, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("setm.10", 6'h00, 1'b0, 7'h10, 7'h00, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("setm.both", 6'h00, 1'b0, 7'h10, 7'h00, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("setm.dec09", 6'h00, 1'b0, 7'h09, 7'h00, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("setm.exit", 6'h00, 1'b0, 7'h10, 7'h00, 2'b00, 1'b1, 1'b0);

    // 12 h display sweep over every hour, walked in SET_H.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int h = 0; h < 24; h++) begin
      h12 = (h % 12 == 0) ? 12 : (h % 12);
      fmt12 = 1'b1;
      #1;
      checkVal($sformatf("h12.disp%0d", h), 8'(disp_hour), to_bcd(h12));
      checkVal($sformatf("h12.pm%0d", h), 8'(nAM_PM), (h >= 12) ? 8'd1 : 8'd0);
      fmt12 = 1'b0;
      #1;
      checkVal($sformatf("h24.disp%0d", h), 8'(disp_hour), to_bcd(h));
      if (h < 23)
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Reset in the middle of a minute edit, with other inputs active.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst", 6'h23, 1'b1, 7'h10, 7'h00, 2'b10, 1'b1, 1'b0);
    @(negedge clk);
    nrst     = 1'b0;
    btn_inc  = 1'b1;
    tick_1hz = 1'b1;
    @(posedge clk);
    #1;
    btn_inc  = 1'b0;
    tick_1hz = 1'b0;
    checkOutput("mid_rst", 6'h00, 1'b0, 7'h00, 7'h00, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("post_rst", 6'h00, 1'b0, 7'h00, 7'h01, 2'b00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
